// File: rtl/fifo_stream_rdr_if.sv
// fifo_stream_rdr_if: sync_fifo read port plus the framed valid/ready
// stream, seen from the reader (master) and its environment (slave).
interface fifo_stream_rdr_if #(
   parameter int DATA_WIDTH = 3,
   parameter int CNT_WIDTH  = 3
);
   logic                  en;
   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic [CNT_WIDTH-1:0]  pkt_cnt;

   modport master (
      input  en,
      input  fifo_empty,
      input  fifo_rd_data,
      input  m_ready,
      output fifo_rd_en,
      output m_valid,
      output m_data,
      output m_last,
      output pkt_cnt
   );

   modport slave (
      output en,
      output fifo_empty,
      output fifo_rd_data,
      output m_ready,
      input  fifo_rd_en,
      input  m_valid,
      input  m_data,
      input  m_last,
      input  pkt_cnt
   );
endinterface

// File: rtl/fifo_stream_rdr.sv
// fifo_stream_rdr: reads sync_fifo, hides its 1-cycle read latency in a
// 2-entry buffer and frames the words into fixed-length packets.
module fifo_stream_rdr #(
   parameter int DATA_WIDTH = 3,
   parameter int PKT_LEN    = 4,
   parameter int CNT_WIDTH  = 3
) (
   input  logic              clk,
   input  logic              rst,
   fifo_stream_rdr_if.master io
);

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_BEAT =
      CNT_WIDTH'(PKT_LEN - 1);

   buf_state_t            buf_q, buf_d;
   logic                  pend_q;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic [CNT_WIDTH-1:0]  beat_q, beat_d;
   logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
   logic                  last_q, last_d;
   logic                  valid;
   logic                  pop;
   logic                  rd_en;
   logic [2:0]            occ;

   assign valid = (buf_q != BUF_EMPTY);
   assign pop   = valid & io.m_ready;

   // Occupancy after this cycle, counting the read already in flight.
   assign occ = {1'b0, buf_q} + {2'b00, pend_q} - {2'b00, pop};

   assign rd_en = ~rst & io.en & ~io.fifo_empty & (occ < 3'd2);

   always_comb begin
      buf_d  = buf_q;
      head_d = head_q;
      tail_d = tail_q;
      unique case (buf_q)
         BUF_EMPTY: begin
            if (pend_q) begin
               buf_d  = BUF_ONE;
               head_d = io.fifo_rd_data;
            end
         end
         BUF_ONE: begin
            case ({pop, pend_q})
               2'b11: head_d = io.fifo_rd_data;
               2'b10: buf_d  = BUF_EMPTY;
               2'b01: begin
                  tail_d = io.fifo_rd_data;
                  buf_d  = BUF_TWO;
               end
               default: ;
            endcase
         end
         BUF_TWO: begin
            if (pop) begin
               head_d = tail_q;
               if (pend_q) begin
                  tail_d = io.fifo_rd_data;
               end else begin
                  buf_d = BUF_ONE;
               end
            end
         end
         default: buf_d = BUF_EMPTY;
      endcase
   end

   always_comb begin
      beat_d = beat_q;
      last_d = last_q;
      pkt_d  = pkt_q;
      if (pop) begin
         beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
         last_d = (beat_d == LAST_BEAT);
         if (last_q) begin
            pkt_d = pkt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q  <= BUF_EMPTY;
         pend_q <= 1'b0;
         head_q <= '0;
         tail_q <= '0;
         beat_q <= '0;
         last_q <= (LAST_BEAT == '0);
         pkt_q  <= '0;
      end else begin
         buf_q  <= buf_d;
         pend_q <= rd_en;
         head_q <= head_d;
         tail_q <= tail_d;
         beat_q <= beat_d;
         last_q <= last_d;
         pkt_q  <= pkt_d;
      end
   end

   assign io.fifo_rd_en = rd_en;
   assign io.m_valid    = valid;
   assign io.m_data     = head_q;
   assign io.m_last     = valid & last_q;
   assign io.pkt_cnt    = pkt_q;

   a_no_underflow: assert property (
      @(posedge clk) disable iff (rst)
      io.fifo_rd_en |-> !io.fifo_empty);

   a_no_overrun: assert property (
      @(posedge clk) disable iff (rst)
      (pend_q && buf_q == BUF_TWO) |-> pop);

   a_hold: assert property (
      @(posedge clk) disable iff (rst)
      (valid && !io.m_ready) |=>
      (valid && $stable(io.m_data) && $stable(io.m_last)));

endmodule

// File: tb/tb_fifo_stream_rdr.sv
// Bench for fifo_stream_rdr: FIFO model, directed vectors and a
// scoreboard monitor for PKT_LEN=4 and PKT_LEN=1 instances.
module tb_fifo_stream_rdr;

   localparam int DW = 3;
   localparam int CW = 3;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [CW-1:0] pkt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_stream_rdr_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) io4 ();
   fifo_stream_rdr_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) io1 ();

   fifo_stream_rdr #(
      .DATA_WIDTH(DW), .PKT_LEN(4), .CNT_WIDTH(CW)
   ) u_dut4 (.clk(clk), .rst(rst), .io(io4));

   fifo_stream_rdr #(
      .DATA_WIDTH(DW), .PKT_LEN(1), .CNT_WIDTH(CW)
   ) u_dut1 (.clk(clk), .rst(rst), .io(io1));

   always #5 clk = ~clk;

   logic [DW-1:0] fq4[$];
   logic [DW-1:0] fq1[$];
   exp_t          sb4[$];
   exp_t          sb1[$];

   int n_checks = 0;
   int n_fail   = 0;

   int t2_data[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
   int t2_last[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
   int t2_pkt[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
   int t3_data[6] = '{2, 4, 6, 1, 3, 5};
   int t3_last[6] = '{0, 0, 0, 1, 0, 0};
   int t3_pkt[6]  = '{0, 0, 0, 0, 1, 1};
   int t4_data[8] = '{7, 6, 5, 4, 3, 2, 1, 0};
   int t6_data[4] = '{1, 3, 5, 7};
   int t6_last[4] = '{0, 0, 0, 1};
   int t7_data[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
   int t7_pkt[9]  = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Scoreboard monitor: compares every accepted word.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (io4.fifo_rd_en) check("rd4_while_empty", int'(io4.fifo_empty), 0);
         if (io1.fifo_rd_en) check("rd1_while_empty", int'(io1.fifo_empty), 0);
         if (io4.m_valid && io4.m_ready) begin
            if (sb4.size() == 0) begin
               check("unexpected_word4", int'(io4.m_data), -1);
            end else begin
               e = sb4.pop_front();
               check("data4", int'(io4.m_data), int'(e.data));
               check("last4", int'(io4.m_last), int'(e.last));
               check("pkt4", int'(io4.pkt_cnt), int'(e.pkt));
            end
         end
         if (io1.m_valid && io1.m_ready) begin
            if (sb1.size() == 0) begin
               check("unexpected_word1", int'(io1.m_data), -1);
            end else begin
               e = sb1.pop_front();
               check("data1", int'(io1.m_data), int'(e.data));
               check("last1", int'(io1.m_last), int'(e.last));
               check("pkt1", int'(io1.pkt_cnt), int'(e.pkt));
            end
         end
      end
   end

   // One clock; the FIFO model answers a read one cycle later.
   task automatic tick();
      logic r4, r1;
      #1;
      r4 = io4.fifo_rd_en;
      r1 = io1.fifo_rd_en;
      @(posedge clk);
      #1;
      if (r4 && fq4.size() > 0) io4.fifo_rd_data = fq4.pop_front();
      if (r1 && fq1.size() > 0) io1.fifo_rd_data = fq1.pop_front();
      io4.fifo_empty = (fq4.size() == 0);
      io1.fifo_empty = (fq1.size() == 0);
      #1;
   endtask

   task automatic push4(int d, bit expd, int l, int p);
      exp_t e;
      fq4.push_back(DW'(d));
      io4.fifo_empty = 1'b0;
      if (expd) begin
         e.data = DW'(d);
         e.last = l[0];
         e.pkt  = CW'(p);
         sb4.push_back(e);
      end
   endtask

   task automatic push1(int d, int p);
      exp_t e;
      fq1.push_back(DW'(d));
      io1.fifo_empty = 1'b0;
      e.data = DW'(d);
      e.last = 1'b1;
      e.pkt  = CW'(p);
      sb1.push_back(e);
   endtask

   task automatic do_reset();
      io4.en = 1'b0;
      io1.en = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic drain(string name, int budget);
      for (int i = 0; i < budget; i++) begin
         if (sb4.size() == 0 && sb1.size() == 0 &&
             !io4.m_valid && !io1.m_valid) break;
         tick();
      end
      check(name, sb4.size() + sb1.size(), 0);
   endtask

   initial begin
      int first_rd, first_v, last_v, vcnt, rdc, bad;
      io4.en = 1'b0;
      io1.en = 1'b0;
      io4.m_ready = 1'b1;
      io1.m_ready = 1'b1;
      io4.fifo_empty = 1'b1;
      io1.fifo_empty = 1'b1;
      io4.fifo_rd_data = '0;
      io1.fifo_rd_data = '0;

      // Reset with an empty FIFO and everything enabled
      rst = 1'b1;
      io4.en = 1'b1;
      io1.en = 1'b1;
      #2;
      check("rst_valid4", int'(io4.m_valid), 0);
      check("rst_data4", int'(io4.m_data), 0);
      check("rst_last4", int'(io4.m_last), 0);
      check("rst_last1", int'(io1.m_last), 0);
      check("rst_rd_en4", int'(io4.fifo_rd_en), 0);
      tick();
      tick();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (io4.fifo_rd_en || io4.m_valid) bad++;
         if (io1.fifo_rd_en || io1.m_valid) bad++;
         tick();
      end
      check("idle_10_cycles", bad, 0);
      check("idle_pkt_cnt", int'(io4.pkt_cnt), 0);
      io1.en = 1'b0;

      // 8 words at full rate: latency, order, framing
      io4.en = 1'b0;
      for (int i = 0; i < 8; i++) push4(t2_data[i], 1'b1, t2_last[i], t2_pkt[i]);
      io4.en = 1'b1;
      first_rd = -1; first_v = -1; last_v = -1; vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (io4.fifo_rd_en && first_rd < 0) first_rd = i;
         if (io4.m_valid) begin
            if (first_v < 0) first_v = i;
            last_v = i;
            vcnt++;
         end
         tick();
      end
      check("first_rd_cycle", first_rd, 0);
      check("rd_to_valid_latency", first_v - first_rd, 2);
      check("burst_words", vcnt, 8);
      check("burst_no_gaps", last_v - first_v, 7);
      check("burst_pkt_cnt", int'(io4.pkt_cnt), 2);
      check("burst_sb_empty", sb4.size(), 0);

      // Backpressure: only two reads, head held, then full-rate drain
      do_reset();
      io4.m_ready = 1'b0;
      for (int i = 0; i < 6; i++) push4(t3_data[i], 1'b1, t3_last[i], t3_pkt[i]);
      io4.en = 1'b1;
      rdc = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (io4.fifo_rd_en) rdc++;
         tick();
      end
      check("bp_reads", rdc, 2);
      check("bp_valid", int'(io4.m_valid), 1);
      check("bp_head_data", int'(io4.m_data), 2);
      check("bp_head_last", int'(io4.m_last), 0);
      io4.m_ready = 1'b1;
      first_v = -1; last_v = -1; vcnt = 0;
      for (int i = 0; i < 15; i++) begin
         #1;
         if (io4.m_valid) begin
            if (first_v < 0) first_v = i;
            last_v = i;
            vcnt++;
         end
         tick();
      end
      check("bp_words", vcnt, 6);
      check("bp_no_gaps", last_v - first_v, 5);
      check("bp_pkt_cnt", int'(io4.pkt_cnt), 1);

      // Alternating m_ready
      do_reset();
      for (int i = 0; i < 8; i++) push4(t4_data[i], 1'b1, t2_last[i], t2_pkt[i]);
      io4.en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (sb4.size() == 0 && !io4.m_valid) break;
         io4.m_ready = (i % 2 == 0);
         tick();
      end
      check("alt_sb_empty", sb4.size(), 0);
      check("alt_pkt_cnt", int'(io4.pkt_cnt), 2);
      io4.m_ready = 1'b1;

      // en high for exactly one issuing cycle
      do_reset();
      push4(5, 1'b1, 0, 0);
      push4(6, 1'b0, 0, 0);
      push4(7, 1'b0, 0, 0);
      io4.en = 1'b1;
      #1;
      check("en_pulse_rd", int'(io4.fifo_rd_en), 1);
      tick();
      io4.en = 1'b0;
      rdc = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (io4.fifo_rd_en) rdc++;
         tick();
      end
      check("en_low_no_reads", rdc, 0);
      check("en_low_word_out", sb4.size(), 0);
      check("en_low_fifo_left", fq4.size(), 2);
      fq4.delete();
      io4.fifo_empty = 1'b1;

      // Asynchronous reset with words buffered and in flight
      do_reset();
      io4.m_ready = 1'b0;
      push4(3, 1'b0, 0, 0);
      push4(4, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) push4(t6_data[i], 1'b1, t6_last[i], 0);
      io4.en = 1'b1;
      tick();
      tick();
      check("pre_rst_valid", int'(io4.m_valid), 1);
      check("pre_rst_data", int'(io4.m_data), 3);
      rst = 1'b1;
      #1;
      check("async_rst_valid", int'(io4.m_valid), 0);
      check("async_rst_data", int'(io4.m_data), 0);
      check("async_rst_rd_en", int'(io4.fifo_rd_en), 0);
      check("async_rst_pkt", int'(io4.pkt_cnt), 0);
      tick();
      rst = 1'b0;
      io4.m_ready = 1'b1;
      drain("rst_restart_drain", 30);
      check("rst_restart_pkt", int'(io4.pkt_cnt), 1);
      io4.en = 1'b0;

      // PKT_LEN = 1: last on every word, pkt_cnt wraps
      do_reset();
      for (int i = 0; i < 9; i++) push1(t7_data[i], t7_pkt[i]);
      io1.en = 1'b1;
      drain("pkt1_drain", 40);
      check("pkt1_pkt_cnt", int'(io1.pkt_cnt), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
